// File: rtl/aes_out_serializer.sv
// Captures each AES_CORE result on the rising edge of its finished flag, buffers whole
// blocks in a small FIFO and streams them out MS word first over a valid/ready port.
module aes_out_serializer #(
    parameter int DEPTH  = 4,
    parameter int WORD_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [127:0]             core_data_out,
    input  logic                     core_finished,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [WORD_W-1:0]        m_data,
    output logic                     m_last,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    localparam int NW = 128 / WORD_W;
    localparam int AW = $clog2(DEPTH);
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    logic                fin_q;
    logic [127:0]        mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q;
    logic [AW-1:0]       rd_ptr_q;
    logic [AW:0]         count_q;
    logic [AW:0]         count_d;
    logic                overflow_q;
    state_t              state_q;
    logic [127:0]        shreg_q;
    logic [IW-1:0]       idx_q;
    logic                valid_q;

    logic cap;
    logic full;
    logic word_done;
    logic is_last;
    logic pop;
    logic wr_en;
    logic drop;

    // A pop in SEND only happens on the handshake of the final word, so blocks chain without a bubble.
    always_comb begin
        cap       = core_finished & ~fin_q;
        full      = (count_q == (AW+1)'(DEPTH));
        word_done = valid_q & m_ready;
        is_last   = (idx_q == IW'(NW - 1));
        pop       = (count_q != '0) & ((state_q == IDLE) | (word_done & is_last));
        wr_en     = cap & (~full | pop);
        drop      = cap & full & ~pop;
        count_d   = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!wr_en && pop) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fin_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            fin_q   <= core_finished;
            count_q <= count_d;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clr_ovf) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // Block storage carries no reset; only entries already written are ever read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= core_data_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        shreg_q <= mem_q[rd_ptr_q];
                        idx_q   <= '0;
                        valid_q <= 1'b1;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (word_done) begin
                        if (is_last && pop) begin
                            shreg_q <= mem_q[rd_ptr_q];
                            idx_q   <= '0;
                        end else if (is_last) begin
                            shreg_q <= shreg_q << WORD_W;
                            idx_q   <= '0;
                            valid_q <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            shreg_q <= shreg_q << WORD_W;
                            idx_q   <= idx_q + IW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign m_valid    = valid_q;
    assign m_data     = shreg_q[127 -: WORD_W];
    assign m_last     = valid_q & is_last;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule
